// File: rtl/add_tree_pkg.sv
// add_tree_pkg: shared types and constants for the add_tree_64 scheduler.
//   length_mode_e : job length mode (64/32/16-lane groups, reserved)
//   result_t      : result FIFO entry {mode, four packed lane sums, payload}
package add_tree_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned LANES     = 64;
  localparam int unsigned TREE_LAT  = 12;
  localparam int unsigned PAYLOAD_W = 1024;

  typedef enum logic [1:0] {
    LM_64  = 2'b00,
    LM_32  = 2'b01,
    LM_16  = 2'b10,
    LM_RSV = 2'b11
  } length_mode_e;

  typedef struct packed {
    length_mode_e             mode;
    logic [3:0][DW-1:0]       sum;   // lane k in sum[k]
    logic [PAYLOAD_W-1:0]     in0;
  } result_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_push, i_data  : write request/data (dropped when o_full)
//   o_full          : no free entry
//   i_pop           : consume head when o_valid
//   o_valid, o_data : head entry present / head data (zero when empty)
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_idx, rd_idx;
  logic             wr_wrap, rd_wrap;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when indices coincide.
  assign o_valid = !((wr_idx == rd_idx) && (wr_wrap == rd_wrap));
  assign o_full  =  (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && o_valid;
  assign o_data  = o_valid ? mem[rd_idx] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_idx  <= '0;
      wr_wrap <= 1'b0;
      rd_idx  <= '0;
      rd_wrap <= 1'b0;
    end else begin
      if (do_push) begin
        if (wr_idx == AW'(DEPTH - 1)) begin
          wr_idx  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (do_pop) begin
        if (rd_idx == AW'(DEPTH - 1)) begin
          rd_idx  <= '0;
          rd_wrap <= ~rd_wrap;
        end else begin
          rd_idx  <= rd_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_idx] <= i_data;
  end

endmodule

// File: rtl/add_tree_sched.sv
// add_tree_sched: credit-based scheduler around the add_tree_64 pipeline.
//   i_s_*  : job input (valid/ready, length mode, payload, 64 addends)
//   o_t_*  : tree drive (enable, valid, mode, payload, addends)
//   i_t_*  : tree bypass outputs and mode-specific sums
//   o_m_*  : result output (valid/ready, mode, packed lane sums, payload)
//   o_err  : sticky [0]=reserved mode seen, [1]=tree valid mismatch/overflow
module add_tree_sched
  import add_tree_pkg::*;
#(
  parameter int unsigned TREE_LAT   = add_tree_pkg::TREE_LAT,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DW         = add_tree_pkg::DW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [1:0]           i_s_length_mode,
  input  logic [PAYLOAD_W-1:0] i_s_in0,
  input  logic [PAYLOAD_W-1:0] i_s_in1,
  output logic                 o_t_en,
  output logic                 o_t_valid,
  output logic [1:0]           o_t_length_mode,
  output logic [PAYLOAD_W-1:0] o_t_in0,
  output logic [PAYLOAD_W-1:0] o_t_in1,
  input  logic                 i_t_valid_byp,
  input  logic [1:0]           i_t_length_mode_byp,
  input  logic [PAYLOAD_W-1:0] i_t_in0_byp,
  input  logic [DW-1:0]        i_t_sum64_0,
  input  logic [DW-1:0]        i_t_sum32_0,
  input  logic [DW-1:0]        i_t_sum32_1,
  input  logic [DW-1:0]        i_t_sum16_0,
  input  logic [DW-1:0]        i_t_sum16_1,
  input  logic [DW-1:0]        i_t_sum16_2,
  input  logic [DW-1:0]        i_t_sum16_3,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [1:0]           o_m_length_mode,
  output logic [4*DW-1:0]      o_m_sum,
  output logic [PAYLOAD_W-1:0] o_m_in0,
  output logic [1:0]           o_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]       credit;
  logic                accept, pop;
  logic [TREE_LAT-1:0] chk_sr;
  logic                fifo_full;
  result_t             wr_entry, rd_entry;

  // Tree never stalls: credits reserve a FIFO slot for every in-flight job.
  assign o_t_en    = 1'b1;
  assign o_s_ready = (credit != '0);
  assign accept    = i_s_valid && o_s_ready;
  assign pop       = o_m_valid && i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      credit <= CW'(FIFO_DEPTH);
    end else if (accept && !pop) begin
      credit <= credit - 1'b1;
    end else if (pop && !accept && (credit != CW'(FIFO_DEPTH))) begin
      credit <= credit + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_t_valid       <= 1'b0;
      o_t_length_mode <= '0;
      o_t_in0         <= '0;
      o_t_in1         <= '0;
    end else begin
      o_t_valid <= accept;
      if (accept) begin
        o_t_length_mode <= i_s_length_mode;
        o_t_in0         <= i_s_in0;
        o_t_in1         <= i_s_in1;
      end
    end
  end

  // Tail of chk_sr lines up with the tree's bypass valid for the same job.
  always_ff @(posedge i_clk) begin
    if (i_rst) chk_sr <= '0;
    else       chk_sr <= {chk_sr[TREE_LAT-2:0], o_t_valid};
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.mode = length_mode_e'(i_t_length_mode_byp);
    wr_entry.in0  = i_t_in0_byp;
    case (length_mode_e'(i_t_length_mode_byp))
      LM_64: wr_entry.sum[0] = i_t_sum64_0;
      LM_32: begin
        wr_entry.sum[0] = i_t_sum32_0;
        wr_entry.sum[1] = i_t_sum32_1;
      end
      LM_16: begin
        wr_entry.sum[0] = i_t_sum16_0;
        wr_entry.sum[1] = i_t_sum16_1;
        wr_entry.sum[2] = i_t_sum16_2;
        wr_entry.sum[3] = i_t_sum16_3;
      end
      default: wr_entry.sum = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= '0;
    end else begin
      if (i_t_valid_byp && (length_mode_e'(i_t_length_mode_byp) == LM_RSV)) o_err[0] <= 1'b1;
      if ((chk_sr[TREE_LAT-1] != i_t_valid_byp) || (i_t_valid_byp && fifo_full)) o_err[1] <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_t_valid_byp),
    .i_data  (wr_entry),
    .o_full  (fifo_full),
    .i_pop   (i_m_ready),
    .o_valid (o_m_valid),
    .o_data  (rd_entry)
  );

  assign o_m_length_mode = rd_entry.mode;
  assign o_m_sum         = rd_entry.sum;
  assign o_m_in0         = rd_entry.in0;

endmodule
